// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the two data masters, the arbiter and data_ram.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [3:0]  m0_sel;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_stall;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [3:0]  m1_sel;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;

  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_rdata, m0_ack, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    output m1_rdata, m1_ack,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_rdata, m0_ack, m0_stall,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    input  m1_rdata, m1_ack,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared data RAM / MMIO port. Master 0 (processor)
// has priority; a saturating starvation counter forces master 1 through after
// STARVE_LIMIT consecutive contested wins by master 0. The slave side is a
// purely combinational 2:1 mux selected by the registered grant state.
module data_bus_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  data_bus_arbiter_if.slave   bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } grant_t;

  grant_t     grant_q, grant_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Grant and starvation counter registers; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      grant_q      <= grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next grant from the requests seen at this edge; counter tracks how many
  // times in a row master 1 has been passed over while it was waiting.
  always_comb begin
    grant_d      = IDLE;
    starve_cnt_d = 4'd0;
    if (bus.m0_req && bus.m1_req) begin
      grant_d = (starve_cnt_q >= LIMIT) ? G1 : G0;
    end else if (bus.m0_req) begin
      grant_d = G0;
    end else if (bus.m1_req) begin
      grant_d = G1;
    end
    if (bus.m1_req && (grant_d == G0)) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
    end
  end

  // Slave mux, acknowledges and read-data steering. A granted master that has
  // dropped req simply gets a dead cycle: no RAM enable and no ack.
  always_comb begin
    bus.ram_ce    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 32'd0;
    bus.ram_sel   = 4'd0;
    bus.ram_wdata = 32'd0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.m0_rdata  = 32'd0;
    bus.m1_rdata  = 32'd0;
    case (grant_q)
      G0: begin
        bus.ram_ce    = bus.m0_req;
        bus.ram_we    = bus.m0_we;
        bus.ram_addr  = bus.m0_addr;
        bus.ram_sel   = bus.m0_sel;
        bus.ram_wdata = bus.m0_wdata;
        bus.m0_ack    = bus.m0_req;
      end
      G1: begin
        bus.ram_ce    = bus.m1_req;
        bus.ram_we    = bus.m1_we;
        bus.ram_addr  = bus.m1_addr;
        bus.ram_sel   = bus.m1_sel;
        bus.ram_wdata = bus.m1_wdata;
        bus.m1_ack    = bus.m1_req;
      end
      default: ;
    endcase
    if (bus.m0_ack) bus.m0_rdata = bus.ram_rdata;
    if (bus.m1_ack) bus.m1_rdata = bus.ram_rdata;
    bus.m0_stall = bus.m0_req & ~bus.m0_ack;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a small byte-lane RAM model.
module tb_data_bus_arbiter;

  localparam logic [31:0] SW_VAL  = 32'h0000_A5C3;
  localparam logic [31:0] OLD_VAL = 32'h1111_1111;

  logic clk;
  logic rst;
  logic preload;
  int   n_cmp;
  int   n_err;

  data_bus_arbiter_if bus ();

  data_bus_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word array, byte-lane writes at the edge ending the ack cycle
  logic [31:0] mem [0:255];
  assign bus.ram_rdata = mem[bus.ram_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      mem[8'h00] <= 32'h0;
      mem[8'h40] <= 32'h0;
      mem[8'h41] <= 32'h0;
      mem[8'h80] <= SW_VAL;
      mem[8'hC0] <= OLD_VAL;
    end else if (bus.ram_ce && bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_sel[b]) mem[bus.ram_addr[9:2]][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
    bus.m0_sel = 4'hF; bus.m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
    bus.m1_sel = 4'hF; bus.m1_wdata = wdata;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    preload = 1'b1;
    set_m0(1'b1, 1'b0, 32'h0, 32'h0);
    set_m1(1'b1, 1'b0, 32'h0, 32'h0);

    // Reset held with both masters requesting
    tick();
    tick();
    preload = 1'b0;
    check("rst_ram_ce", 32'(bus.ram_ce), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
    check("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
    check("rst_m0_stall", 32'(bus.m0_stall), 32'd1);
    check("rst_m0_rdata", bus.m0_rdata, 32'd0);

    // First edge after release grants master 0
    rst = 1'b0;
    tick();
    check("post_rst_m0_ack", 32'(bus.m0_ack), 32'd1);
    check("post_rst_m1_ack", 32'(bus.m1_ack), 32'd0);
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("idle_ram_ce", 32'(bus.ram_ce), 32'd0);

    // Master 0 write then back-to-back read
    set_m0(1'b1, 1'b1, 32'h100, 32'h1234_5678);
    #1;
    check("wr_wait_ack", 32'(bus.m0_ack), 32'd0);
    check("wr_wait_stall", 32'(bus.m0_stall), 32'd1);
    tick();
    check("wr_ack", 32'(bus.m0_ack), 32'd1);
    check("wr_ram_we", 32'(bus.ram_we), 32'd1);
    check("wr_ram_addr", bus.ram_addr, 32'h100);
    check("wr_ram_wdata", bus.ram_wdata, 32'h1234_5678);
    check("wr_stall", 32'(bus.m0_stall), 32'd0);
    check("wr_m1_ack", 32'(bus.m1_ack), 32'd0);
    tick();
    set_m0(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    check("rd_ack", 32'(bus.m0_ack), 32'd1);
    check("rd_data", bus.m0_rdata, 32'h1234_5678);
    check("rd_m1_ack", 32'(bus.m1_ack), 32'd0);
    check("rd_m1_rdata", bus.m1_rdata, 32'd0);
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Continuous contention: G0,G0,G0,G1 repeating
    set_m0(1'b1, 1'b0, 32'h0, 32'h0);
    set_m1(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    check("cont_first_stall", 32'(bus.m0_stall), 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("cont_m0_ack_%0d", i), 32'(bus.m0_ack), (i % 4 == 3) ? 32'd0 : 32'd1);
      check($sformatf("cont_m1_ack_%0d", i), 32'(bus.m1_ack), (i % 4 == 3) ? 32'd1 : 32'd0);
      check($sformatf("cont_stall_%0d", i), 32'(bus.m0_stall), (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Master 1 alone reading the switch register
    set_m1(1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    check("m1_wait_ack", 32'(bus.m1_ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("m1_ack_%0d", i), 32'(bus.m1_ack), 32'd1);
      check($sformatf("m1_rdata_%0d", i), bus.m1_rdata, SW_VAL);
    end
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("m1_drop_cnt", 32'(dut.starve_cnt_q), 32'd0);
    check("m1_drop_ce", 32'(bus.ram_ce), 32'd0);
    check("m1_drop_ack", 32'(bus.m1_ack), 32'd0);

    // Dead grant: one-cycle m0 pulse carrying a write
    set_m0(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D);
    tick();
    set_m0(1'b0, 1'b1, 32'h104, 32'hCAFE_F00D);
    #1;
    check("dead_ce", 32'(bus.ram_ce), 32'd0);
    check("dead_ack", 32'(bus.m0_ack), 32'd0);
    check("dead_stall", 32'(bus.m0_stall), 32'd0);
    tick();

    // Async reset in the middle of a master 1 write
    set_m1(1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF);
    tick();
    check("m1wr_ack", 32'(bus.m1_ack), 32'd1);
    check("m1wr_we", 32'(bus.ram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ce", 32'(bus.ram_ce), 32'd0);
    check("arst_we", 32'(bus.ram_we), 32'd0);
    check("arst_m1_ack", 32'(bus.m1_ack), 32'd0);
    check("arst_m1_rdata", bus.m1_rdata, 32'd0);
    tick();
    rst = 1'b0;
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Read back: 0x300 keeps old value, 0x104 was never written
    set_m0(1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    check("rb_300_ack", 32'(bus.m0_ack), 32'd1);
    check("rb_300_data", bus.m0_rdata, OLD_VAL);
    tick();
    set_m0(1'b1, 1'b0, 32'h104, 32'h0);
    #1;
    check("rb_104_data", bus.m0_rdata, 32'd0);
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
